// File: rtl/poly_basemul.sv
// Streaming Kyber base-case multiplier: accepts NTT-domain coefficient pairs and emits
// the Montgomery-domain products r0, r1 of each degree-1 pair, bit-exact to PQClean.
module poly_basemul #(
    parameter int KYBER_Q    = 3329,
    parameter int KYBER_QINV = -3327
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic               o_valid,
    output logic signed [15:0] o_data,
    output logic               o_last,
    output logic               o_busy
);

    localparam logic signed [31:0] Q_W    = 32'(KYBER_Q);
    localparam logic signed [31:0] QINV_W = 32'(KYBER_QINV);

    // Upper half of the PQClean zeta table; pair k uses entry k>>1, negated for odd k.
    localparam logic signed [15:0] ZETA [64] = '{
        -16'sd1103,  16'sd430,   16'sd555,   16'sd843,  -16'sd1251,  16'sd871,   16'sd1550,  16'sd105,
         16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,   16'sd1574,  16'sd1653,
        -16'sd246,   16'sd778,   16'sd1159, -16'sd147,  -16'sd777,   16'sd1483, -16'sd602,   16'sd1119,
        -16'sd1590,  16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,  -16'sd75,
         16'sd817,   16'sd1097,  16'sd603,   16'sd610,   16'sd1322, -16'sd1285, -16'sd1465,  16'sd384,
        -16'sd1215, -16'sd136,   16'sd1218, -16'sd1335, -16'sd874,   16'sd220,  -16'sd1187, -16'sd1659,
        -16'sd1185, -16'sd1530, -16'sd1278,  16'sd794,  -16'sd1510, -16'sd854,  -16'sd870,   16'sd478,
        -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958,  -16'sd1460,  16'sd1522,  16'sd1628
    };

    function automatic logic signed [31:0] mul16(input logic signed [15:0] x, input logic signed [15:0] y);
        logic signed [31:0] xe;
        logic signed [31:0] ye;
        xe = x;
        ye = y;
        return xe * ye;
    endfunction

    // v - t*q is an exact multiple of 2^16, so the shift drops only zero bits.
    function automatic logic signed [15:0] mont(input logic signed [31:0] v);
        logic signed [15:0] t;
        logic signed [31:0] d;
        t = 16'(v * QINV_W);
        d = v - 32'(t) * Q_W;
        d = d >>> 16;
        return d[15:0];
    endfunction

    logic [7:0]         r_in_idx;
    logic [7:0]         r_out_idx;
    logic signed [15:0] r_a0;
    logic signed [15:0] r_b0;
    logic               r_s1_vld;
    logic signed [15:0] r_s1_m11;
    logic signed [15:0] r_s1_m00;
    logic signed [15:0] r_s1_r1;
    logic signed [15:0] r_s1_z;
    logic               r_s2_vld;
    logic signed [15:0] r_s2_r1;
    logic               r_valid;
    logic signed [15:0] r_data;
    logic               r_last;
    logic               r_busy;

    logic               w_acc_even;
    logic               w_acc_odd;
    logic [7:0]         w_in_idx_nxt;
    logic signed [15:0] w_zeta;
    logic signed [15:0] w_m11;
    logic signed [15:0] w_m00;
    logic signed [15:0] w_r1;
    logic signed [15:0] w_r0;
    logic               w_emit;
    logic signed [15:0] w_data_nxt;
    logic               w_busy_nxt;

    // Beat qualification, stage-1 products, stage-2 r0 and the output/busy next state.
    always_comb begin
        w_acc_even   = i_valid && !r_in_idx[0];
        w_acc_odd    = i_valid && r_in_idx[0];
        w_in_idx_nxt = r_in_idx;
        if (i_valid) begin
            w_in_idx_nxt = r_in_idx + 8'd1;
        end else begin
            w_in_idx_nxt = r_in_idx;
        end
        w_zeta = ZETA[r_in_idx[7:2]];
        if (r_in_idx[1]) begin
            w_zeta = -ZETA[r_in_idx[7:2]];
        end else begin
            w_zeta = ZETA[r_in_idx[7:2]];
        end
        w_m11 = mont(mul16(i_a, i_b));
        w_m00 = mont(mul16(r_a0, r_b0));
        w_r1  = mont(mul16(r_a0, i_b)) + mont(mul16(i_a, r_b0));
        w_r0  = mont(mul16(r_s1_m11, r_s1_z)) + r_s1_m00;
        // Odd beats are at least two cycles apart, so stage 1 and stage 2 never emit together.
        w_emit     = r_s1_vld || r_s2_vld;
        w_data_nxt = 16'sd0;
        if (r_s1_vld) begin
            w_data_nxt = w_r0;
        end else if (r_s2_vld) begin
            w_data_nxt = r_s2_r1;
        end else begin
            w_data_nxt = 16'sd0;
        end
        w_busy_nxt = w_in_idx_nxt[0] || w_acc_odd || w_emit;
    end

    // Input holding registers, two-stage pipeline and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_in_idx  <= 8'd0;
            r_out_idx <= 8'd0;
            r_a0      <= 16'sd0;
            r_b0      <= 16'sd0;
            r_s1_vld  <= 1'b0;
            r_s1_m11  <= 16'sd0;
            r_s1_m00  <= 16'sd0;
            r_s1_r1   <= 16'sd0;
            r_s1_z    <= 16'sd0;
            r_s2_vld  <= 1'b0;
            r_s2_r1   <= 16'sd0;
            r_valid   <= 1'b0;
            r_data    <= 16'sd0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_in_idx <= w_in_idx_nxt;
            if (w_acc_even) begin
                r_a0 <= i_a;
                r_b0 <= i_b;
            end
            r_s1_vld <= w_acc_odd;
            if (w_acc_odd) begin
                r_s1_m11 <= w_m11;
                r_s1_m00 <= w_m00;
                r_s1_r1  <= w_r1;
                r_s1_z   <= w_zeta;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_r1 <= r_s1_r1;
            end
            r_valid <= w_emit;
            r_data  <= w_data_nxt;
            r_last  <= w_emit && (r_out_idx == 8'd255);
            if (w_emit) begin
                r_out_idx <= r_out_idx + 8'd1;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_poly_basemul.sv
// Directed and randomized bench for poly_basemul: a reference base multiplier fills an
// expected-output queue (value, cycle, last flag) that a negedge monitor checks.
module tb_poly_basemul;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [15:0] i_a = 16'sd0;
    logic signed [15:0] i_b = 16'sd0;
    logic               o_valid;
    logic signed [15:0] o_data;
    logic               o_last;
    logic               o_busy;

    poly_basemul dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .i_a    (i_a),
        .i_b    (i_b),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_last (o_last),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    localparam shortint ZT [64] = '{
        -16'sd1103,  16'sd430,   16'sd555,   16'sd843,  -16'sd1251,  16'sd871,   16'sd1550,  16'sd105,
         16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,   16'sd1574,  16'sd1653,
        -16'sd246,   16'sd778,   16'sd1159, -16'sd147,  -16'sd777,   16'sd1483, -16'sd602,   16'sd1119,
        -16'sd1590,  16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,  -16'sd75,
         16'sd817,   16'sd1097,  16'sd603,   16'sd610,   16'sd1322, -16'sd1285, -16'sd1465,  16'sd384,
        -16'sd1215, -16'sd136,   16'sd1218, -16'sd1335, -16'sd874,   16'sd220,  -16'sd1187, -16'sd1659,
        -16'sd1185, -16'sd1530, -16'sd1278,  16'sd794,  -16'sd1510, -16'sd854,  -16'sd870,   16'sd478,
        -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958,  -16'sd1460,  16'sd1522,  16'sd1628
    };

    typedef struct {
        shortint data;
        int      cyc;
        bit      last;
    } exp_t;

    typedef struct {
        shortint a0, a1, b0, b1;
        int      pair;
        shortint r0, r1;
    } vec_t;

    exp_t     exp_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    int       n_last = 0;
    int       cyc = 0;
    bit       mon_en = 1'b0;
    bit [7:0] m_idx = 8'd0;
    bit [7:0] p_idx = 8'd0;
    shortint  m_a0 = 16'sd0;
    shortint  m_b0 = 16'sd0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference C behaviour: fqmul(x,y) = montgomery_reduce((int32)x*y).
    function automatic shortint fqmul(input shortint x, input shortint y);
        int      v;
        shortint t;
        v = int'(x) * int'(y);
        t = shortint'(v * -3327);
        return shortint'((v - int'(t) * 3329) >>> 16);
    endfunction

    task automatic ref_pair(input int k, input shortint a0, input shortint a1, input shortint b0,
                            input shortint b1, output shortint r0, output shortint r1);
        shortint z;
        z  = (k % 2 == 0) ? ZT[k / 2] : shortint'(-ZT[k / 2]);
        r0 = fqmul(a1, b1);
        r0 = fqmul(r0, z);
        r0 = shortint'(r0 + fqmul(a0, b0));
        r1 = fqmul(a0, b1);
        r1 = shortint'(r1 + fqmul(a1, b0));
    endtask

    function automatic shortint rnd_coef();
        return shortint'(int'($urandom_range(0, 6656)) - 3328);
    endfunction

    task automatic push(input shortint d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        e.last = (p_idx == 8'd255);
        exp_q.push_back(e);
        p_idx++;
    endtask

    // One input cycle; odd beats queue r0 at drive-cycle+2 and r1 at +3.
    task automatic drive(input bit v, input shortint a, input shortint b,
                         input bit has_exp, input shortint er0, input shortint er1);
        shortint r0, r1;
        @(posedge i_clk);
        #1;
        i_valid = v;
        i_a     = a;
        i_b     = b;
        if (v) begin
            if (!m_idx[0]) begin
                m_a0 = a;
                m_b0 = b;
            end else begin
                if (has_exp) begin
                    r0 = er0;
                    r1 = er1;
                end else begin
                    ref_pair(int'(m_idx[7:1]), m_a0, a, m_b0, b, r0, r1);
                end
                push(r0, cyc + 2);
                push(r1, cyc + 3);
            end
            m_idx++;
        end
    endtask

    task automatic idle();
        drive(1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0);
    endtask

    task automatic rbeat();
        drive(1'b1, rnd_coef(), rnd_coef(), 1'b0, 16'sd0, 16'sd0);
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_a     = rnd_coef();
        i_b     = rnd_coef();
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > cyc) void'(exp_q.pop_back());
        m_idx = 8'd0;
        p_idx = 8'd0;
        m_a0  = 16'sd0;
        m_b0  = 16'sd0;
        repeat (ncyc - 1) begin
            @(posedge i_clk);
            #1;
            i_a = rnd_coef();
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_a     = 16'sd0;
        i_b     = 16'sd0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
        idle();
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Output monitor: every emitted coefficient must match the queue head in value, cycle and last.
    always @(negedge i_clk) begin
        exp_t e;
        if (mon_en) begin
            if (o_valid) begin
                if (o_last) n_last++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_data", int'(o_data), int'(e.data));
                    chk("out_cycle", cyc, e.cyc);
                    chk("o_last", int'(o_last), int'(e.last));
                end
            end else begin
                chk("idle_o_data", int'(o_data), 0);
                chk("idle_o_last", int'(o_last), 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_output", 0, int'(e.data) + 100000);
                end
            end
        end
    end

    function automatic vec_t mk(input shortint a0, input shortint a1, input shortint b0,
                                input shortint b1, input int pair, input shortint r0, input shortint r1);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
        v.pair = pair; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    vec_t vt[7];
    int   last_before;
    bit   found;

    initial begin
        shortint e0, e1;
        vt[0] = mk(16'sd1, 16'sd0, 16'sd1, 16'sd0, 0, 16'sd169, 16'sd0);
        vt[1] = mk(16'sd0, 16'sd1, 16'sd0, 16'sd1, 0, -16'sd456, 16'sd0);
        vt[2] = mk(16'sd0, 16'sd1, 16'sd0, 16'sd1, 1, 16'sd456, 16'sd0);
        vt[3] = mk(16'sd0, 16'sd0, 16'sd0, 16'sd0, 0, 16'sd0, 16'sd0);
        ref_pair(0, 16'sd3328, -16'sd3328, 16'sd3328, -16'sd3328, e0, e1);
        vt[4] = mk(16'sd3328, -16'sd3328, 16'sd3328, -16'sd3328, 0, e0, e1);
        ref_pair(3, -16'sd3328, 16'sd3328, 16'sd3328, -16'sd3328, e0, e1);
        vt[5] = mk(-16'sd3328, 16'sd3328, 16'sd3328, -16'sd3328, 3, e0, e1);
        ref_pair(5, 16'sd1234, -16'sd2000, 16'sd77, 16'sd3001, e0, e1);
        vt[6] = mk(16'sd1234, -16'sd2000, 16'sd77, 16'sd3001, 5, e0, e1);

        // Reset state, with i_valid high during reset.
        do_reset(3);
        @(negedge i_clk);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_last", int'(o_last), 0);
        chk("rst_o_busy", int'(o_busy), 0);
        mon_en = 1'b1;

        // Table-driven pairs; busy must rise after the even beat.
        for (int i = 0; i < 7; i++) begin
            do_reset(2);
            for (int p = 0; p < vt[i].pair; p++) begin
                drive(1'b1, 16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0);
                drive(1'b1, 16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0);
            end
            drive(1'b1, vt[i].a0, vt[i].b0, 1'b0, 16'sd0, 16'sd0);
            drive(1'b1, vt[i].a1, vt[i].b1, 1'b1, vt[i].r0, vt[i].r1);
            @(negedge i_clk);
            chk("busy_after_even", int'(o_busy), 1);
            drain();
        end

        // Even beat held across a long gap, then the odd beat completes the pair.
        do_reset(2);
        rbeat();
        repeat (20) idle();
        @(negedge i_clk);
        chk("busy_while_held", int'(o_busy), 1);
        rbeat();
        rbeat();
        idle();
        rbeat();
        drain();

        // 256 back-to-back beats; busy drops one cycle after o_last.
        do_reset(2);
        last_before = n_last;
        repeat (256) rbeat();
        idle();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge i_clk);
            if (o_last) found = 1'b1;
        end
        chk("last_seen_cont", int'(found), 1);
        chk("busy_at_last", int'(o_busy), 1);
        @(negedge i_clk);
        chk("busy_after_last", int'(o_busy), 0);
        drain();
        chk("last_count_cont", n_last - last_before, 1);

        // Two polynomials with random gaps.
        do_reset(2);
        last_before = n_last;
        for (int n = 0; n < 512; ) begin
            if ($urandom_range(0, 1) == 1) begin
                rbeat();
                n++;
            end else begin
                idle();
            end
        end
        drain();
        chk("last_count_gaps", n_last - last_before, 2);

        // Reset in the middle of a polynomial, then a fresh one restarting at index 0.
        do_reset(2);
        repeat (102) rbeat();
        do_reset(2);
        repeat (5) idle();
        repeat (16) rbeat();
        drain();

        // All-zero polynomial.
        do_reset(2);
        repeat (256) drive(1'b1, 16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_basemul.md
POLY_BASEMUL -- requirements
Module: poly_basemul

Interface
REQ-001 Parameter: KYBER_Q, 3329, modulus used by Montgomery reduction.
REQ-002 Parameter: KYBER_QINV, -3327, q^-1 mod 2^16, signed 16-bit.
REQ-003 Port: i_clk  input  1  rising-edge clock for all state.
REQ-004 Port: i_rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 Port: i_valid  input  1  qualifies i_a/i_b; one coefficient pair accepted per cycle when high.
REQ-006 Port: i_a  input  16  signed coefficient of operand a (NTT domain, |a| < q).
REQ-007 Port: i_b  input  16  signed coefficient of operand b (NTT domain, |b| < q).
REQ-008 Port: o_valid  output  1  qualifies o_data.
REQ-009 Port: o_data  output  16  signed product coefficient, range (-2q, 2q).
REQ-010 Port: o_last  output  1  high with o_valid on output coefficient 255 only.
REQ-011 Port: o_busy  output  1  high while any accepted pair has not yet been fully emitted.

Function
REQ-012 Input: 8-bit counter in_idx, +1 per accepted beat, wraps 255->0; polynomials streamed back-to-back, coefficient order 0..255.
REQ-013 i_valid may drop on any cycle; gaps stall in_idx only; no backpressure, block accepts every valid beat.
REQ-014 Even in_idx: a0/b0 registered. Odd in_idx: a1/b1 taken from ports, pair k = in_idx>>1 launched.
REQ-015 Zeta ROM: 64 signed 16-bit entries = PQClean zetas[64..127] (entry 0 = -1103, entry 1 = 430); pair k uses z = ROM[k>>1] if k even, -ROM[k>>1] if k odd.
REQ-016 fqmul(x,y) = mont(x*y); mont(v): v 32-bit signed, t = low 16 bits of v*KYBER_QINV as signed, result = (v - t*KYBER_Q) >>> 16 (arithmetic).
REQ-017 r0 = mont(mont(a1*b1)*z) + mont(a0*b0); r1 = mont(a0*b1) + mont(a1*b0); 16-bit signed sums, no final reduction; bit-exact to PQClean poly_basemul_montgomery.
REQ-018 Pipeline: odd beat at cycle t -> r0 on o_data, o_valid=1 at t+2; r1 at t+3; fixed, independent of later i_valid.
REQ-019 Even beat of next pair at t+1 and odd beat at t+2 legal: outputs then continuous (t+4, t+5), no collision, no dropped data.
REQ-020 Output counter out_idx, +1 per emitted coefficient, wraps 255->0; o_last = o_valid && out_idx==255.
REQ-021 o_valid low, o_data = 0 on every cycle without an emitted coefficient.
REQ-022 o_busy high from cycle after an even beat until cycle after last pending r1 emitted.
REQ-023 Stream ending after an even beat: a0/b0 held indefinitely; no output until odd beat arrives.

Reset
REQ-024 i_rst_n low at a clock edge: in_idx, out_idx = 0, a0/b0 regs and pipeline = 0; o_valid, o_last, o_busy = 0; o_data = 0.
REQ-025 Reset mid-polynomial discards all in-flight pairs; no output in cycles after reset until new odd beat + 2.
REQ-026 i_valid ignored while i_rst_n low.

Verification
REQ-027 Pair 0 a=(1,0), b=(1,0) -> o_data 169 then 0, o_valid two consecutive cycles starting odd beat + 2.
REQ-028 Pair 0 a=(0,1), b=(0,1) -> r0 = -456, r1 = 0; same on pair 1 -> r0 = 456, r1 = 0 (zeta sign flip).
REQ-029 512 random beats, i_valid random 50% gaps -> output stream bit-exact to C model for two polynomials; o_last exactly twice on coefficient 255.
REQ-030 Continuous i_valid for 256 beats -> o_valid continuous for 256 cycles starting 3 cycles after first beat; o_busy low 1 cycle after o_last.
REQ-031 Reset asserted after in_idx=101 -> no further o_valid; fresh polynomial after release -> out_idx restarts at 0, results match model.
REQ-032 All-zero inputs -> 256 zero outputs; a=b=(3328,-3328) extremes -> no overflow, match model.
